// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits LSB first, odd parity, stop, ACK.
// Optional watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_CYCLES   = 2000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kclk,
  input  logic       kdata,
  output logic       kclk_oe,
  output logic       kdata_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int TMR_MAX_A = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int TMR_MAX   = (TMR_MAX_A > TIMEOUT_CYCLES) ? TMR_MAX_A : TIMEOUT_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE} state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           state, state_nxt;
  logic             kclk_p0, kclk_p1, kclk_p2;
  logic             kdata_p0, kdata_p1;
  logic             fall;
  logic [7:0]       data_r;
  logic             par_r;
  logic [TMR_W-1:0] tmr;
  logic [3:0]       edge_cnt;
  logic             kdata_drv;
  logic             err_r;
  logic             inh_end, start_end, wd_exp, tmr_run, tmr_clr, send_entry;

  // Line synchronizers; p2 holds the previous synchronized kclk for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_p0  <= 1'b1;
      kclk_p1  <= 1'b1;
      kclk_p2  <= 1'b1;
      kdata_p0 <= 1'b1;
      kdata_p1 <= 1'b1;
    end else begin
      kclk_p0  <= kclk;
      kclk_p1  <= kclk_p0;
      kclk_p2  <= kclk_p1;
      kdata_p0 <= kdata;
      kdata_p1 <= kdata_p0;
    end
  end

  assign fall       = kclk_p2 & ~kclk_p1;
  assign inh_end    = (state == INHIBIT) && (tmr == TMR_W'(INHIBIT_CYCLES - 1));
  assign start_end  = (state == START) && (tmr == TMR_W'(START_CYCLES - 1));
  assign send_entry = (state != SEND) && (state_nxt == SEND);
  // ACK and WAIT_IDLE keep the count running so the watchdog spans the whole frame.
  assign tmr_clr    = (state_nxt != state) && !(state_nxt inside {ACK, WAIT_IDLE});

`ifdef PS2_HOST_TX_TIMEOUT_EN
  assign wd_exp  = (state inside {SEND, ACK, WAIT_IDLE}) && (tmr == TMR_W'(TIMEOUT_CYCLES));
  assign tmr_run = state inside {INHIBIT, START, SEND, ACK, WAIT_IDLE};
`else
  assign wd_exp  = 1'b0;
  assign tmr_run = state inside {INHIBIT, START};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (tx_valid) state_nxt = INHIBIT;
      INHIBIT:   if (inh_end) state_nxt = START;
      START:     if (start_end) state_nxt = SEND;
      SEND:      if (fall && edge_cnt == 4'd9) state_nxt = ACK;
      ACK:       if (fall) state_nxt = WAIT_IDLE;
      WAIT_IDLE: if (kclk_p1 && kdata_p1) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (wd_exp) state_nxt = IDLE;
  end

  always_comb begin
    kclk_oe  = state inside {INHIBIT, START};
    kdata_oe = (state == START) || ((state == SEND) && kdata_drv && !wd_exp);
    tx_ready = (state == IDLE);
    tx_done  = ((state == WAIT_IDLE) && kclk_p1 && kdata_p1) || wd_exp;
    tx_err   = tx_done && (err_r || wd_exp);
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && tx_valid) begin
      data_r <= tx_data;
      par_r  <= odd_parity(tx_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr       <= '0;
      edge_cnt  <= '0;
      kdata_drv <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      if (tmr_clr)      tmr <= '0;
      else if (tmr_run) tmr <= tmr + TMR_W'(1);

      if (send_entry)                                      edge_cnt <= '0;
      else if ((state == SEND || state == ACK) && fall)    edge_cnt <= edge_cnt + 4'd1;

      // Start bit stays driven until the device clocks the first data bit.
      if (send_entry) kdata_drv <= 1'b1;
      else if (state == SEND && fall) begin
        if (edge_cnt < 4'd8)       kdata_drv <= ~data_r[edge_cnt[2:0]];
        else if (edge_cnt == 4'd8) kdata_drv <= ~par_r;
        else                       kdata_drv <= 1'b0;
      end

      if (state == ACK && fall) err_r <= kdata_p1;
    end
  end

endmodule
